// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch front end: FSM states, reset PC
// and the mapping of fetch counters onto mips_perf_cnt_0..2.
package mips_pkg;

  typedef enum logic [1:0] {
    IF_INIT = 2'd0,
    IF_REQ  = 2'd1,
    IF_WAIT = 2'd2,
    IF_EXE  = 2'd3
  } if_state_e;

  localparam logic [31:0] MIPS_RESET_PC = 32'h0000_0000;

  localparam int unsigned PERF_IDX_CYCLE       = 0;
  localparam int unsigned PERF_IDX_INST        = 1;
  localparam int unsigned PERF_IDX_FETCH_STALL = 2;
  localparam int unsigned PERF_NUM_CNT         = 3;

  // Instruction fetches are word aligned; the low two bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/mips_ifetch_if.sv
// Instruction-memory request/response handshake between fetch and memory.
interface mips_ifetch_if;

  logic [31:0] PC;
  logic        Inst_Req_Valid;
  logic        Inst_Req_Ack;
  logic [31:0] Instruction;
  logic        Inst_Valid;
  logic        Inst_Ack;

  modport master (
    output PC,
    output Inst_Req_Valid,
    input  Inst_Req_Ack,
    input  Instruction,
    input  Inst_Valid,
    output Inst_Ack
  );

  modport slave (
    input  PC,
    input  Inst_Req_Valid,
    output Inst_Req_Ack,
    output Instruction,
    output Inst_Valid,
    input  Inst_Ack
  );

endinterface

// File: rtl/mips_perf_counter.sv
// Enabled wrap-around counter with synchronous clear (clear has priority).
module mips_perf_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/mips_ifetch.sv
// Instruction-fetch front end: PC, memory handshakes, instruction register
// and fetch-side performance counters.
module mips_ifetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = MIPS_RESET_PC,
  parameter int unsigned CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  mips_ifetch_if.master     mem,
  output logic [31:0]       ir,
  output logic              ir_valid,
  input  logic              exe_done,
  input  logic [31:0]       next_pc,
  output logic [CNT_W-1:0]  cnt_cycle,
  output logic [CNT_W-1:0]  cnt_inst,
  output logic [CNT_W-1:0]  cnt_fetch_stall
);

  if_state_e   state;
  if_state_e   state_n;
  logic [31:0] pc_q;
  logic        req_valid;
  logic        rsp_ack;
  logic        exe_valid;
  logic        ir_load;
  logic        pc_load;
  logic [PERF_NUM_CNT-1:0] cnt_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IF_INIT;
    end else begin
      state <= state_n;
    end
  end

  // Handshake outputs decode state only; each state samples a single input.
  always_comb begin
    state_n   = state;
    req_valid = 1'b0;
    rsp_ack   = 1'b0;
    exe_valid = 1'b0;
    ir_load   = 1'b0;
    pc_load   = 1'b0;
    case (state)
      IF_INIT: begin
        state_n = IF_REQ;
      end
      IF_REQ: begin
        req_valid = 1'b1;
        if (mem.Inst_Req_Ack) state_n = IF_WAIT;
      end
      IF_WAIT: begin
        rsp_ack = 1'b1;
        if (mem.Inst_Valid) begin
          ir_load = 1'b1;
          state_n = IF_EXE;
        end
      end
      IF_EXE: begin
        exe_valid = 1'b1;
        if (exe_done) begin
          pc_load = 1'b1;
          state_n = IF_REQ;
        end
      end
      default: state_n = IF_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
      ir   <= '0;
    end else begin
      if (pc_load) pc_q <= word_align(next_pc);
      if (ir_load) ir   <= mem.Instruction;
    end
  end

  assign mem.PC             = pc_q;
  assign mem.Inst_Req_Valid = req_valid;
  assign mem.Inst_Ack       = rsp_ack;
  assign ir_valid           = exe_valid;

  always_comb begin
    cnt_en                       = '0;
    cnt_en[PERF_IDX_CYCLE]       = 1'b1;
    cnt_en[PERF_IDX_INST]        = pc_load;
    cnt_en[PERF_IDX_FETCH_STALL] = (state == IF_REQ) || (state == IF_WAIT);
  end

  mips_perf_counter #(.CNT_W(CNT_W)) u_cnt_cycle (
    .clk   (clk),
    .clr   (rst),
    .en    (cnt_en[PERF_IDX_CYCLE]),
    .count (cnt_cycle)
  );

  mips_perf_counter #(.CNT_W(CNT_W)) u_cnt_inst (
    .clk   (clk),
    .clr   (rst),
    .en    (cnt_en[PERF_IDX_INST]),
    .count (cnt_inst)
  );

  mips_perf_counter #(.CNT_W(CNT_W)) u_cnt_fetch_stall (
    .clk   (clk),
    .clr   (rst),
    .en    (cnt_en[PERF_IDX_FETCH_STALL]),
    .count (cnt_fetch_stall)
  );

endmodule

// File: doc/mips_ifetch.md
Name: mips_ifetch

Overview:
Instruction-fetch front end for the real-memory MIPS core. Owns the PC and runs the instruction request and response handshakes with memory. Holds the fetched word in an instruction register, presents it to the decode/execute datapath, and advances the PC when execute signals completion. Also provides fetch-side performance counters for the mips_perf_cnt_* outputs.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
CNT_W, 32, width of each performance counter.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
PC  out  32  fetch address; registered
Inst_Req_Valid  out  1  instruction request valid
Inst_Req_Ack  in  1  memory accepts the request
Instruction  in  32  memory response data
Inst_Valid  in  1  response data valid
Inst_Ack  out  1  fetch unit ready for the response
ir  out  32  latched instruction, to decode
ir_valid  out  1  ir holds a live instruction for execute
exe_done  in  1  execute has committed the current instruction
next_pc  in  32  PC selected by execute (PC+4 or branch/jump target)
cnt_cycle  out  CNT_W  cycles since reset
cnt_inst  out  CNT_W  retired instructions
cnt_fetch_stall  out  CNT_W  cycles spent in the REQ or WAIT states

Behaviour:
- FSM states: INIT, REQ, WAIT, EXE; one-hot or binary encoding.
- Reset (rst=1 at a clk edge, from any state including mid-handshake):
  - state <= INIT; PC <= RESET_PC; ir <= 0; all counters <= 0.
  - During INIT: Inst_Req_Valid=0, Inst_Ack=0, ir_valid=0.
- INIT -> REQ unconditionally on the next cycle.
- REQ:
  - Inst_Req_Valid=1, held until accepted; never retracted.
  - PC stable.
  - Inst_Req_Ack=1 in the same cycle -> WAIT next cycle.
- WAIT:
  - Inst_Ack=1.
  - Inst_Valid=1 -> ir <= Instruction; move to EXE next cycle.
  - Inst_Valid is ignored in all other states.
- EXE:
  - ir_valid=1; ir and PC held stable.
  - exe_done=1 -> PC <= {next_pc[31:2], 2'b00}; cnt_inst += 1; move to REQ next cycle.
  - exe_done is ignored outside EXE.
- Minimum loop is 3 cycles per instruction (REQ, WAIT, EXE), assuming zero-wait memory and same-cycle exe_done.
- Inst_Req_Valid, Inst_Ack and ir_valid are pure decodes of state; they must not depend combinationally on the ack/valid inputs.
- Counters:
  - cnt_cycle increments every non-reset cycle, including INIT.
  - cnt_fetch_stall increments in every REQ or WAIT cycle.
  - All counters wrap modulo 2^CNT_W with no saturation.
- Simultaneous events: none possible across states. Each state samples exactly one input, so a stale Inst_Valid during REQ is dropped.
- Response before request accept is illegal memory behaviour and is not handled.

Decomposition:
- Shared package mips_pkg:
  - state encodings IF_INIT, IF_REQ, IF_WAIT, IF_EXE;
  - RESET_PC default;
  - perf-counter index constants mapping counters to mips_perf_cnt_0..2.
- One natural sub-module, mips_perf_counter: a CNT_W-bit enabled counter with synchronous clear, instantiated three times.

Test Plan:
- Reset held 3 cycles, then released -> cycle 1: Inst_Req_Valid=0, PC=0. Cycle 2: Inst_Req_Valid=1; all counters 0 while reset is held.
- Zero-wait memory (ack and valid same cycle), exe_done tied 1, next_pc=PC+4 -> PC sequence 0,4,8,C at 3-cycle spacing; cnt_inst=4 after 12 cycles.
- Inst_Req_Ack delayed 2 cycles, Inst_Valid delayed 3 cycles -> Inst_Req_Valid held steady; ir updates only on the valid cycle; cnt_fetch_stall=7 for that instruction.
- In EXE with ir=32'h1000_0003 (beq), exe_done=1, next_pc=32'h0000_0013 -> PC=32'h0000_0010; next request issued with that address.
- Reset asserted while in WAIT with Inst_Valid=1 in the same cycle -> ir stays 0, PC=RESET_PC, state INIT.
- Preload counter to 32'hFFFF_FFFF via force, run one cycle -> cnt_cycle=0.
